// File: rtl/regs_wb_sched.sv
// rtl/regs_wb_sched.sv - scoreboard and round-robin write-port scheduler for the DLX register file
// Stalls decode on RAW/WAW against in-flight destinations; issues one regs write per cycle.
module regs_wb_sched #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rs1,
  input  logic [4:0]      iss_rs2,
  input  logic            iss_use1,
  input  logic            iss_use2,
  input  logic [4:0]      iss_rd,
  input  logic            iss_wr,
  output logic            iss_stall,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [DW-1:0]   alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic [DW-1:0]   mem_data,
  output logic            mem_ready,
  output logic            WB,
  output logic [4:0]      Rd,
  output logic [DW-1:0]   reg_s,
  input  logic            flush,
  output logic [NREG-1:0] busy,
  output logic [5:0]      pending,
  output logic            wb_err
);

  typedef enum logic {LAST_ALU = 1'b0, LAST_MEM = 1'b1} last_e;

  last_e           last_q, last_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic [5:0]      pending_q, pending_d;
  logic            wb_q, wb_d;
  logic [4:0]      rd_q, rd_d;
  logic [DW-1:0]   data_q, data_d;
  logic            err_q, err_d;

  logic            grant_alu, grant_mem, hs;
  logic            issue_set, retire_clr;
  logic [4:0]      g_rd;
  logic [DW-1:0]   g_data;

  function automatic logic is_busy(input logic [NREG-1:0] v, input logic [4:0] idx);
    return (idx != 5'd0) && v[idx];
  endfunction

  always_comb begin
    iss_stall = iss_valid && ((iss_use1 && is_busy(busy_q, iss_rs1)) ||
                              (iss_use2 && is_busy(busy_q, iss_rs2)) ||
                              (iss_wr   && is_busy(busy_q, iss_rd)));
    // On a tie the requester that was not granted last time wins.
    grant_alu  = alu_valid && (!mem_valid || last_q == LAST_MEM);
    grant_mem  = mem_valid && (!alu_valid || last_q == LAST_ALU);
    hs         = grant_alu || grant_mem;
    g_rd       = grant_alu ? alu_rd : mem_rd;
    g_data     = grant_alu ? alu_data : mem_data;
    issue_set  = iss_valid && !iss_stall && iss_wr && (iss_rd != 5'd0);
    // Only a still-busy target retires; writes to cleared registers leave pending alone.
    retire_clr = wb_q && is_busy(busy_q, rd_q);
  end

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;

  always_comb begin
    busy_d    = busy_q;
    pending_d = pending_q;
    wb_d      = hs;
    rd_d      = rd_q;
    data_d    = data_q;
    err_d     = err_q;
    last_d    = last_q;

    if (retire_clr) busy_d[rd_q] = 1'b0;
    if (issue_set)  busy_d[iss_rd] = 1'b1;

    if (issue_set && !retire_clr) begin
      pending_d = pending_q + 6'd1;
    end else if (!issue_set && retire_clr) begin
      pending_d = pending_q - 6'd1;
    end

    if (flush) begin
      busy_d    = '0;
      pending_d = '0;
    end

    if (hs) begin
      rd_d   = g_rd;
      data_d = g_data;
      last_d = grant_mem ? LAST_MEM : LAST_ALU;
      if (g_rd != 5'd0 && !is_busy(busy_q, g_rd)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= '0;
      pending_q <= '0;
      wb_q      <= 1'b0;
      rd_q      <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      last_q    <= LAST_ALU;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
      wb_q      <= wb_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      err_q     <= err_d;
      last_q    <= last_d;
    end
  end

  assign WB      = wb_q;
  assign Rd      = rd_q;
  assign reg_s   = data_q;
  assign busy    = busy_q;
  assign pending = pending_q;
  assign wb_err  = err_q;

endmodule

// File: tb/tb_regs_wb_sched.sv
// tb/tb_regs_wb_sched.sv - directed table plus randomized run of regs_wb_sched against a reference model
module tb_regs_wb_sched;

  logic        clk;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        iss_use1, iss_use2, iss_wr;
  logic        iss_stall;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        WB;
  logic [4:0]  Rd;
  logic [31:0] reg_s;
  logic        flush;
  logic [31:0] busy;
  logic [5:0]  pending;
  logic        wb_err;

  regs_wb_sched #(.NREG(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_use1(iss_use1), .iss_use2(iss_use2), .iss_rd(iss_rd), .iss_wr(iss_wr),
    .iss_stall(iss_stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .WB(WB), .Rd(Rd), .reg_s(reg_s), .flush(flush),
    .busy(busy), .pending(pending), .wb_err(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: set of in-flight registers plus the write-port contents.
  bit [31:0] m_busy;
  bit        m_last_mem;
  bit        m_wb;
  bit [4:0]  m_rd;
  bit [31:0] m_data;
  bit        m_err;
  bit        c_stall, c_ardy, c_mrdy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit used_busy(input bit use_it, input logic [4:0] idx);
    return use_it && idx != 5'd0 && m_busy[idx];
  endfunction

  // Inputs are already applied; checks combinational outputs, advances the model, checks after the edge.
  task automatic cycle();
    bit [31:0] nb;
    bit [4:0]  g_rd;
    #1;
    c_stall = iss_valid && (used_busy(iss_use1, iss_rs1) || used_busy(iss_use2, iss_rs2) ||
                            used_busy(iss_wr, iss_rd));
    if (alu_valid && mem_valid) begin
      c_mrdy = !m_last_mem;
      c_ardy = m_last_mem;
    end else begin
      c_ardy = alu_valid;
      c_mrdy = mem_valid;
    end
    chk("iss_stall", iss_stall, c_stall);
    chk("alu_ready", alu_ready, c_ardy);
    chk("mem_ready", mem_ready, c_mrdy);

    if (rst) begin
      m_busy = '0; m_last_mem = 1'b0; m_wb = 1'b0; m_rd = '0; m_data = '0; m_err = 1'b0;
    end else begin
      nb = m_busy;
      if (m_wb && m_rd != 0) nb[m_rd] = 1'b0;
      if (iss_valid && !c_stall && iss_wr && iss_rd != 0) nb[iss_rd] = 1'b1;
      if (flush) nb = '0;
      if (c_ardy || c_mrdy) begin
        g_rd = c_ardy ? alu_rd : mem_rd;
        if (g_rd != 0 && !m_busy[g_rd]) m_err = 1'b1;
        m_wb = 1'b1;
        m_rd = g_rd;
        m_data = c_ardy ? alu_data : mem_data;
        m_last_mem = c_mrdy;
      end else begin
        m_wb = 1'b0;
      end
      m_busy = nb;
    end

    @(posedge clk);
    #1;
    chk("WB", WB, m_wb);
    chk("Rd", Rd, m_rd);
    chk("reg_s", reg_s, m_data);
    chk("busy", busy, m_busy);
    chk("pending", pending, $countones(m_busy));
    chk("wb_err", wb_err, m_err);
  endtask

  typedef struct {
    logic       rst, flush;
    logic       iv;
    logic [4:0] rs1; logic u1;
    logic [4:0] rs2; logic u2;
    logic [4:0] rd;  logic wr;
    logic       av;  logic [4:0] ard;
    logic       mv;  logic [4:0] mrd;
    logic       e_stall, e_ardy, e_mrdy;
    logic       e_wb; logic [4:0] e_rd; logic [5:0] e_pend; logic e_err;
  } vec_t;

  function automatic vec_t mk(
      input logic r, input logic fl, input logic iv,
      input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
      input logic [4:0] rd, input logic wr,
      input logic av, input logic [4:0] ard, input logic mv, input logic [4:0] mrd,
      input logic es, input logic ea, input logic em,
      input logic ew, input logic [4:0] erd, input logic [5:0] ep, input logic ee);
    vec_t v;
    v.rst = r; v.flush = fl; v.iv = iv;
    v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd; v.wr = wr;
    v.av = av; v.ard = ard; v.mv = mv; v.mrd = mrd;
    v.e_stall = es; v.e_ardy = ea; v.e_mrdy = em;
    v.e_wb = ew; v.e_rd = erd; v.e_pend = ep; v.e_err = ee;
    return v;
  endfunction

  function automatic logic [4:0] pick_rd();
    int q[$];
    for (int i = 1; i < 32; i++) if (m_busy[i]) q.push_back(i);
    if (q.size() > 0 && $urandom_range(0, 3) != 0) return 5'(q[$urandom_range(0, q.size() - 1)]);
    return 5'($urandom_range(0, 31));
  endfunction

  vec_t tbl[$];

  initial begin
    //            rst fl iv rs1 u1 rs2 u2 rd wr  av ard mv mrd  stl ar mr  wb rd pend err
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0,   0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 7, 1,  0, 0, 0, 0,   0, 0, 0,   0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 7, 1, 0, 0, 0, 0,  0, 0, 0, 0,   1, 0, 0,   0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 7, 1, 0, 0, 0, 0,  1, 7, 0, 0,   1, 1, 0,   1, 7, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 7, 1, 0, 0,  0, 0, 0, 0,   1, 0, 0,   0, 7, 0, 0));
    tbl.push_back(mk(0, 0, 1, 7, 1, 0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0,   0, 7, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 3, 1,  0, 0, 0, 0,   0, 0, 0,   0, 7, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 5, 1,  0, 0, 0, 0,   0, 0, 0,   0, 7, 2, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 3, 1,  1, 3, 1, 5,   1, 0, 1,   1, 5, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 3, 0, 0,   0, 1, 0,   1, 3, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0,   0, 3, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0,   0, 0, 0,   0, 3, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 9,   0, 0, 1,   1, 9, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0,   0, 9, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0,   0, 9, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0,   0, 0, 0,   0, 9, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 2, 1,  0, 0, 0, 0,   0, 0, 0,   0, 9, 2, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 24, 1, 0, 0, 0, 0,   0, 0, 0,   0, 9, 3, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 4, 1,  0, 0, 0, 0,   0, 0, 0,   0, 9, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 4, 1,  0, 0, 0, 0,   0, 0, 0,   0, 9, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0,   0, 0, 0,   0, 9, 2, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 11, 1, 1, 4, 0, 0,   0, 1, 0,   1, 4, 3, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 12, 1, 0, 0, 1, 10,  0, 0, 1,   0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 11, 1, 10, 0, 0, 1,   1, 10, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 11, 0, 0,  0, 1, 0,   1, 11, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0,   0, 11, 0, 1));

    m_busy = '0; m_last_mem = 1'b0; m_wb = 1'b0; m_rd = '0; m_data = '0; m_err = 1'b0;

    foreach (tbl[i]) begin
      rst = tbl[i].rst; flush = tbl[i].flush;
      iss_valid = tbl[i].iv; iss_rs1 = tbl[i].rs1; iss_use1 = tbl[i].u1;
      iss_rs2 = tbl[i].rs2; iss_use2 = tbl[i].u2; iss_rd = tbl[i].rd; iss_wr = tbl[i].wr;
      alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = 32'd111111;
      mem_valid = tbl[i].mv; mem_rd = tbl[i].mrd; mem_data = 32'd222222;
      cycle();
      chk($sformatf("tbl%0d_stall", i), c_stall, tbl[i].e_stall);
      chk($sformatf("tbl%0d_alu_ready", i), c_ardy, tbl[i].e_ardy);
      chk($sformatf("tbl%0d_mem_ready", i), c_mrdy, tbl[i].e_mrdy);
      chk($sformatf("tbl%0d_WB", i), WB, tbl[i].e_wb);
      chk($sformatf("tbl%0d_Rd", i), Rd, tbl[i].e_rd);
      chk($sformatf("tbl%0d_pending", i), pending, tbl[i].e_pend);
      chk($sformatf("tbl%0d_wb_err", i), wb_err, tbl[i].e_err);
    end
    chk("tbl_reg_s_after_alu", reg_s, 32'd111111);

    // Randomized traffic; requesters hold their request until granted.
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 59) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      iss_valid = 1'($urandom_range(0, 1));
      iss_rs1   = 5'($urandom_range(0, 15));
      iss_rs2   = 5'($urandom_range(0, 15));
      iss_use1  = 1'($urandom_range(0, 1));
      iss_use2  = 1'($urandom_range(0, 1));
      iss_rd    = 5'($urandom_range(0, 15));
      iss_wr    = ($urandom_range(0, 3) != 0);
      if (!alu_valid || c_ardy) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_rd    = pick_rd();
        alu_data  = $urandom;
      end
      if (!mem_valid || c_mrdy) begin
        mem_valid = ($urandom_range(0, 2) != 0);
        mem_rd    = pick_rd();
        mem_data  = $urandom;
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
